multi_chn_spi_sender: RTL and testbench
=======================================

// Module: multi_chn_spi_sender
// PURPOSE
//  SPI-master side of the multi-channel readout. When the readout controller raises
//  ZYNQ_RD_EN after end-of-sequence, this block:
//   - reads every buffered sample of every channel from the sample RAM;
//   - shifts the samples out to the Zynq in one SPI frame, MSB first;
//   - pulses SPI_complete, which returns the controller to IDLE.
//  It sits between the per-channel sample RAM and the Zynq SPI pins.
// PARAMETERS
//  N_CHN      4    number of digitizer channels (>=1)
//  N_SAMPLES  16   samples stored per channel (>=1)
//  DATA_W     16   bits per sample word (>=2)
//  CLK_DIV    4    clk cycles per SCLK half-period (>=1)
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  reset        in   1       synchronous, active-high
//  ZYNQ_RD_EN   in   1       readout request from controller; level, held high until after SPI_complete
//  mem_rd_en    out  1       sample RAM read strobe
//  mem_addr     out  AW      AW=$clog2(N_CHN*N_SAMPLES) (min 1); addr = chn*N_SAMPLES + sample
//  mem_data     in   DATA_W  RAM read data; valid exactly 1 cycle after the mem_rd_en cycle
//  SCLK         out  1       SPI clock, idle low (mode 0)
//  MOSI         out  1       SPI data; changes only while SCLK is low
//  CS_N         out  1       SPI chip select, active low, low for the whole frame
//  SPI_complete out  1       1-cycle pulse, frame finished
//  spi_abort    out  1       1-cycle pulse, frame abandoned because ZYNQ_RD_EN dropped
//  busy         out  1       high from frame start through the SPI_complete/spi_abort cycle
// BEHAVIOUR
//  Reset values: all outputs 0 except CS_N=1. mem_addr=0. State IDLE, rd_en_q=0.
//  Registered outputs; no combinational path from any input to any output.
//  Start: in IDLE, ZYNQ_RD_EN=1 with rd_en_q=0 (rising edge) -> FETCH.
//   - CS_N=0 and busy=1 from the next cycle.
//   - A level still high after completion does not restart; a new rising edge is needed.
//  FETCH (1 cycle): mem_rd_en=1, mem_addr = current word index -> LOAD.
//  LOAD (1 cycle): shift reg <= mem_data, MOSI <= mem_data[DATA_W-1], SCLK=0 -> SHIFT.
//  SHIFT, per bit:
//   - SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
//   - At the end of each high phase, SCLK->0 and MOSI <= next bit.
//   - After bit 0's high phase: if words remain, word index+1 -> FETCH; else -> DONE.
//   - SCLK is held low and CS_N low through FETCH/LOAD between words.
//  DONE (1 cycle): CS_N=1, SCLK=0, SPI_complete=1, busy=1 -> IDLE.
//  Word order: ch0 s0..s(N_SAMPLES-1), then ch1, ... Word index wraps to 0 only at frame end.
//  Timing:
//   - Each word takes 2 + 2*DATA_W*CLK_DIV cycles (defaults: 130).
//   - SPI_complete is asserted N_CHN*N_SAMPLES*(2+2*DATA_W*CLK_DIV) cycles after the first CS_N=0 cycle.
//  Abort: ZYNQ_RD_EN=0 in FETCH/LOAD/SHIFT -> next cycle:
//   - CS_N=1, SCLK=0, MOSI=0, mem_rd_en=0;
//   - spi_abort=1 for 1 cycle with busy=1, then IDLE;
//   - no SPI_complete is produced.
//  ZYNQ_RD_EN falling in the DONE cycle is normal (not an abort).
//  Reset mid-frame: immediate return to the reset values; no SPI_complete or spi_abort pulse.
//  Simultaneous: reset has priority over everything; abort has priority over the end-of-word transition.
// TESTING
//  T1 Reset: reset 3 cycles with ZYNQ_RD_EN=1
//     -> CS_N=1, SCLK=0, MOSI=0, SPI_complete=0, busy=0; no frame starts after release until a new rising edge.
//  T2 Full frame, defaults, RAM[i]=16'hA500+i
//     -> 64 words, MOSI sampled on SCLK rise equals A500..A53F MSB first;
//     -> CS_N low for exactly 8320 cycles; SPI_complete one cycle as CS_N rises.
//  T3 Handshake: readout controller model driving ZYNQ_RD_EN from EOS
//     -> exactly one frame per EOS; held ZYNQ_RD_EN never triggers a second frame.
//  T4 Abort: drop ZYNQ_RD_EN during word 5, bit 7
//     -> next cycle CS_N=1, SCLK=0, one spi_abort pulse, no SPI_complete;
//     -> a new rising edge restarts at mem_addr=0.
//  T5 Corners: N_CHN=1, N_SAMPLES=1, DATA_W=2, CLK_DIV=1
//     -> frame of 6 cycles; SCLK pattern 0,1,0,1; address stays 0.
//  T6 Reset mid-SHIFT at word 10 -> outputs at reset values next cycle; no completion or abort pulse.

Source files
------------

// File: rtl/multi_chn_spi_sender.sv
// SPI-master frame sender: streams every buffered sample of every channel to the Zynq in one mode-0 SPI frame.
// Each word costs 2 + 2*DATA_W*CLK_DIV cycles; a dropped ZYNQ_RD_EN aborts the frame on the next cycle.
module multi_chn_spi_sender #(
    parameter int N_CHN     = 4,
    parameter int N_SAMPLES = 16,
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 4,
    localparam int AW = (N_CHN * N_SAMPLES > 1) ? $clog2(N_CHN * N_SAMPLES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ZYNQ_RD_EN,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS_N,
    output logic              SPI_complete,
    output logic              spi_abort,
    output logic              busy
);
    localparam int NW = N_CHN * N_SAMPLES;
    localparam int BW = $clog2(DATA_W);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_DONE, S_ABORT} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_rd_en_q, r_armed;
    logic [AW-1:0]     r_idx, r_mem_addr;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_bit;
    logic [CW-1:0]     r_div;
    logic              r_mem_rd_en, r_sclk, r_mosi, r_cs_n, r_complete, r_abort, r_busy;
    logic              w_start, w_phase_end, w_word_end, w_last_word;

    // A request level already high when reset releases must not start a frame;
    // r_armed stays clear until the request has been seen low once.
    assign w_start     = r_armed && ZYNQ_RD_EN && !r_rd_en_q;
    assign w_phase_end = (r_div == CW'(CLK_DIV - 1));
    assign w_word_end  = (r_state == S_SHIFT) && r_sclk && w_phase_end && (r_bit == '0);
    assign w_last_word = (r_idx == AW'(NW - 1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = ZYNQ_RD_EN ? S_LOAD : S_ABORT;
            S_LOAD:  w_state_nxt = ZYNQ_RD_EN ? S_SHIFT : S_ABORT;
            S_SHIFT: begin
                if (!ZYNQ_RD_EN)     w_state_nxt = S_ABORT;
                else if (w_word_end) w_state_nxt = w_last_word ? S_DONE : S_FETCH;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rd_en_q   <= 1'b0;
            r_armed     <= 1'b0;
            r_idx       <= '0;
            r_mem_addr  <= '0;
            r_shift     <= '0;
            r_bit       <= '0;
            r_div       <= '0;
            r_mem_rd_en <= 1'b0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_complete  <= 1'b0;
            r_abort     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_en_q   <= ZYNQ_RD_EN;
            if (!ZYNQ_RD_EN) r_armed <= 1'b1;
            r_mem_rd_en <= 1'b0;
            r_complete  <= 1'b0;
            r_abort     <= 1'b0;
            if (w_state_nxt == S_ABORT) begin
                r_cs_n     <= 1'b1;
                r_sclk     <= 1'b0;
                r_mosi     <= 1'b0;
                r_idx      <= '0;
                r_mem_addr <= '0;
                r_abort    <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: if (w_state_nxt == S_FETCH) begin
                        r_cs_n      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= r_idx;
                    end
                    S_LOAD: begin
                        r_shift <= mem_data;
                        r_mosi  <= mem_data[DATA_W-1];
                        r_sclk  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= BW'(DATA_W - 1);
                    end
                    S_SHIFT: begin
                        if (w_phase_end) begin
                            r_div  <= '0;
                            r_sclk <= ~r_sclk;
                            if (r_sclk && r_bit == '0) begin
                                if (w_last_word) begin
                                    r_cs_n     <= 1'b1;
                                    r_complete <= 1'b1;
                                    r_mosi     <= 1'b0;
                                    r_idx      <= '0;
                                    r_mem_addr <= '0;
                                end else begin
                                    r_idx       <= r_idx + AW'(1);
                                    r_mem_rd_en <= 1'b1;
                                    r_mem_addr  <= r_idx + AW'(1);
                                end
                            end else if (r_sclk) begin
                                r_mosi  <= r_shift[DATA_W-2];
                                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                                r_bit   <= r_bit - BW'(1);
                            end
                        end else begin
                            r_div <= r_div + CW'(1);
                        end
                    end
                    S_DONE, S_ABORT: r_busy <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign mem_rd_en    = r_mem_rd_en;
    assign mem_addr     = r_mem_addr;
    assign SCLK         = r_sclk;
    assign MOSI         = r_mosi;
    assign CS_N         = r_cs_n;
    assign SPI_complete = r_complete;
    assign spi_abort    = r_abort;
    assign busy         = r_busy;
endmodule

// File: tb/tb_multi_chn_spi_sender.sv
// Directed bench: default-sized sender plus a minimum-sized corner instance, checked against hand-derived frame timing.
module tb_multi_chn_spi_sender;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        mem_rd_en, SCLK, MOSI, CS_N, SPI_complete, spi_abort, busy;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data = '0;

    logic        en_c = 1'b0;
    logic        mem_rd_en_c, SCLK_c, MOSI_c, CS_N_c, cmp_c, abt_c, busy_c;
    logic [0:0]  mem_addr_c;
    logic [1:0]  mem_data_c = '0;

    multi_chn_spi_sender dut (
        .clk(clk), .reset(reset), .ZYNQ_RD_EN(en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .SCLK(SCLK), .MOSI(MOSI), .CS_N(CS_N), .SPI_complete(SPI_complete),
        .spi_abort(spi_abort), .busy(busy)
    );

    multi_chn_spi_sender #(.N_CHN(1), .N_SAMPLES(1), .DATA_W(2), .CLK_DIV(1)) dut_c (
        .clk(clk), .reset(reset), .ZYNQ_RD_EN(en_c), .mem_rd_en(mem_rd_en_c), .mem_addr(mem_addr_c),
        .mem_data(mem_data_c), .SCLK(SCLK_c), .MOSI(MOSI_c), .CS_N(CS_N_c), .SPI_complete(cmp_c),
        .spi_abort(abt_c), .busy(busy_c)
    );

    // Sample RAM: one-cycle registered read, RAM[i] = 16'hA500 + i.
    always @(posedge clk) begin
        if (mem_rd_en)   mem_data   <= 16'hA500 + {10'd0, mem_addr};
        if (mem_rd_en_c) mem_data_c <= 2'b10;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Line monitor on the default instance.
    logic        mon_clr = 1'b1;
    int          cs_low, n_cmp, n_abt, n_words, nbit, cmp_bad, mosi_bad;
    logic [15:0] acc;
    logic [15:0] words [0:63];
    logic        cs_prev = 1'b1, sclk_prev = 1'b0, mosi_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            cs_low <= 0; n_cmp <= 0; n_abt <= 0; n_words <= 0; nbit <= 0;
            cmp_bad <= 0; mosi_bad <= 0; acc <= '0;
        end else begin
            if (!CS_N) cs_low <= cs_low + 1;
            if (SPI_complete) begin
                n_cmp <= n_cmp + 1;
                if (!(CS_N && !cs_prev)) cmp_bad <= cmp_bad + 1;
            end
            if (spi_abort) n_abt <= n_abt + 1;
            if (SCLK && (MOSI != mosi_prev)) mosi_bad <= mosi_bad + 1;
            if (SCLK && !sclk_prev) begin
                if (nbit == 15) begin
                    if (n_words < 64) words[n_words] <= {acc[14:0], MOSI};
                    n_words <= n_words + 1;
                    nbit    <= 0;
                end else begin
                    acc  <= {acc[14:0], MOSI};
                    nbit <= nbit + 1;
                end
            end
        end
        cs_prev   <= CS_N;
        sclk_prev <= SCLK;
        mosi_prev <= MOSI;
    end

    task automatic clear_mon;
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    // Waits for SPI_complete; cyc counts cycles since the already-observed first CS_N=0 cycle.
    task automatic wait_cmp(input int lim, output int cyc, output bit found);
        found = 1'b0;
        cyc   = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (SPI_complete) begin
                found = 1'b1;
                cyc   = i + 1;
                break;
            end
        end
    endtask

    int         cyc;
    bit         found;
    logic [6:0] tr_sclk, tr_cs, tr_cmp, tr_mosi, tr_addr, tr_abt;

    initial begin
        // T1: reset held with the request high.
        repeat (3) tick();
        check("rst_cs_n", CS_N, 1); check("rst_sclk", SCLK, 0); check("rst_mosi", MOSI, 0);
        check("rst_cmp", SPI_complete, 0); check("rst_busy", busy, 0);
        check("rst_rd_en", mem_rd_en, 0); check("rst_addr", mem_addr, 0); check("rst_abort", spi_abort, 0);
        reset = 1'b0;
        mon_clr = 1'b0;
        repeat (20) tick();
        check("t1_no_start_cs", CS_N, 1); check("t1_no_start_busy", busy, 0);
        check("t1_cs_low_cnt", cs_low, 0);

        // T5: minimum-size corner instance.
        en_c = 1'b1;
        tr_sclk = '0; tr_cs = '0; tr_cmp = '0; tr_mosi = '0; tr_addr = '0; tr_abt = '0;
        for (int i = 0; i < 7; i++) begin
            tick();
            tr_sclk[i] = SCLK_c; tr_cs[i] = CS_N_c; tr_cmp[i] = cmp_c;
            tr_mosi[i] = MOSI_c; tr_addr[i] = mem_addr_c[0]; tr_abt[i] = abt_c;
        end
        check("t5_sclk", tr_sclk, 7'b0101000);
        check("t5_cs_n", tr_cs, 7'b1000000);
        check("t5_cmp", tr_cmp, 7'b1000000);
        check("t5_mosi", tr_mosi, 7'b0001100);
        check("t5_addr", tr_addr, 7'b0000000);
        check("t5_abort", tr_abt, 7'b0000000);
        tick();
        check("t5_idle_busy", busy_c, 0);
        en_c = 1'b0;

        // T2: full default frame from a fresh rising edge.
        en = 1'b0;
        tick(); tick();
        clear_mon();
        en = 1'b1;
        tick();
        check("t2_start_cs", CS_N, 0); check("t2_start_busy", busy, 1);
        check("t2_start_rd", mem_rd_en, 1); check("t2_start_addr", mem_addr, 0);
        wait_cmp(9000, cyc, found);
        check("t2_done_seen", found, 1);
        check("t2_cmp_cycle", cyc, 8320);
        check("t2_cmp_cs_n", CS_N, 1); check("t2_cmp_busy", busy, 1);
        tick();
        check("t2_post_cmp", SPI_complete, 0); check("t2_post_busy", busy, 0);
        check("t2_cs_low", cs_low, 8320); check("t2_n_cmp", n_cmp, 1);
        check("t2_cmp_edge", cmp_bad, 0); check("t2_mosi_stable", mosi_bad, 0);
        check("t2_n_words", n_words, 64);
        for (int i = 0; i < 64; i++) check($sformatf("t2_word%0d", i), words[i], 32'hA500 + i);

        // T3: held level must not retrigger; the controller model then runs one EOS handshake.
        clear_mon();
        repeat (200) tick();
        check("t3_hold_cs_low", cs_low, 0); check("t3_hold_cmp", n_cmp, 0);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        tick();
        check("t3_start_cs", CS_N, 0);
        wait_cmp(9000, cyc, found);
        check("t3_done_seen", found, 1);
        tick();
        en = 1'b0;
        repeat (5) tick();
        check("t3_one_frame", n_cmp, 1); check("t3_cs_low", cs_low, 8320);
        check("t3_n_words", n_words, 64);

        // T4: abort in word 5, bit 7.
        clear_mon();
        en = 1'b1;
        repeat (5 * 130 + 2 + 8 * 8 + 2) tick();
        check("t4_pre_cs", CS_N, 0);
        en = 1'b0;
        tick();
        check("t4_cs_n", CS_N, 1); check("t4_sclk", SCLK, 0); check("t4_mosi", MOSI, 0);
        check("t4_rd_en", mem_rd_en, 0); check("t4_abort", spi_abort, 1);
        check("t4_busy", busy, 1); check("t4_cmp", SPI_complete, 0);
        tick();
        check("t4_abort_end", spi_abort, 0); check("t4_busy_end", busy, 0);
        repeat (5) tick();
        check("t4_n_abt", n_abt, 1); check("t4_n_cmp", n_cmp, 0);
        check("t4_words", n_words, 5); check("t4_word4", words[4], 16'hA504);
        en = 1'b1;
        tick();
        check("t4_restart_rd", mem_rd_en, 1); check("t4_restart_addr", mem_addr, 0);
        check("t4_restart_cs", CS_N, 0);

        // T6: reset in the middle of word 10.
        repeat (10 * 130 + 2 + 20 - 2) tick();
        clear_mon();
        check("t6_pre_cs", CS_N, 0); check("t6_pre_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("t6_cs_n", CS_N, 1); check("t6_sclk", SCLK, 0); check("t6_mosi", MOSI, 0);
        check("t6_busy", busy, 0); check("t6_rd_en", mem_rd_en, 0); check("t6_addr", mem_addr, 0);
        check("t6_cmp", SPI_complete, 0); check("t6_abort", spi_abort, 0);
        tick(); tick();
        reset = 1'b0;
        repeat (20) tick();
        check("t6_no_restart", CS_N, 1); check("t6_n_cmp", n_cmp, 0); check("t6_n_abt", n_abt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
